// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped BTB with 2-bit counters.
// Predicts in fetch, checks and trains from the decode-stage resolution.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic [2:0]        Branch_D,
    input  logic              PCSrcD,
    input  logic [ADDR_W-1:0] PCBranchD,
    output logic              PredTakenF,
    output logic [ADDR_W-1:0] PredTargetF,
    output logic              MispredictD,
    output logic [ADDR_W-1:0] RecoverPCD
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = ADDR_W - IDX_BITS - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic              valid_d;
    logic [ADDR_W-1:0] pc_d;
    logic              pred_taken_d;
    logic [ADDR_W-1:0] pred_target_d;

    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]    tag_f;
    logic                hit_f;

    logic [IDX_BITS-1:0] idx_dc;
    logic [TAG_W-1:0]    tag_dc;
    logic                hit_dc;
    logic                is_branch;
    logic                alias_d;
    logic                train;
    logic                alias_clr;
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_next;

    // Fetch lookup
    assign idx_f = PCF[IDX_BITS+1:2];
    assign tag_f = PCF[ADDR_W-1:IDX_BITS+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign PredTakenF  = hit_f && ctr_q[idx_f][1];
    assign PredTargetF = PredTakenF ? target_q[idx_f]
                                    : PCF + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d       <= 1'b0;
            pc_d          <= '0;
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
        end else if (FlushD) begin
            valid_d      <= 1'b0;
            pred_taken_d <= 1'b0;
        end else if (!StallD) begin
            valid_d       <= 1'b1;
            pc_d          <= PCF;
            pred_taken_d  <= PredTakenF;
            pred_target_d <= PredTargetF;
        end
    end

    // Decode-side resolution
    assign idx_dc    = pc_d[IDX_BITS+1:2];
    assign tag_dc    = pc_d[ADDR_W-1:IDX_BITS+2];
    assign hit_dc    = valid_q[idx_dc] && (tag_q[idx_dc] == tag_dc);
    assign is_branch = valid_d && (Branch_D != 3'b000)
                               && (Branch_D != 3'b111);
    assign alias_d   = valid_d && !is_branch && pred_taken_d;

    assign MispredictD = (is_branch
                          && ((PCSrcD != pred_taken_d)
                              || (PCSrcD
                                  && (pred_target_d != PCBranchD))))
                         || alias_d;

    assign RecoverPCD = (is_branch && PCSrcD) ? PCBranchD
                                              : pc_d + ADDR_W'(4);

    assign train     = is_branch && !StallD;
    assign alias_clr = alias_d && !StallD;
    assign ctr_cur   = ctr_q[idx_dc];

    always_comb begin
        ctr_next = ctr_cur;
        unique case (1'b1)
            PCSrcD && (ctr_cur != 2'b11):  ctr_next = ctr_cur + 2'd1;
            !PCSrcD && (ctr_cur != 2'b00): ctr_next = ctr_cur - 2'd1;
            default:                       ctr_next = ctr_cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (train) begin
            if (hit_dc) begin
                ctr_q[idx_dc] <= ctr_next;
            end else if (PCSrcD) begin
                valid_q[idx_dc] <= 1'b1;
                ctr_q[idx_dc]   <= 2'b10;
            end
        end else if (alias_clr) begin
            valid_q[idx_dc] <= 1'b0;
        end
    end

    // Tag/target need no reset: valid gates every use
    always_ff @(posedge clk) begin
        if (!rst && train && PCSrcD) begin
            tag_q[idx_dc]    <= tag_dc;
            target_q[idx_dc] <= PCBranchD;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against a table-level model,
// plus directed scenarios with hand-computed expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcf;
    logic        stall_d;
    logic        flush_d;
    logic [2:0]  branch_d;
    logic        pcsrc_d;
    logic [31:0] pcbranch_d;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        mispredict_d;
    logic [31:0] recover_pc_d;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model state: per-index table and the fetch-to-decode latch
    bit          mv   [64];
    logic [31:0] mtag [64];
    logic [31:0] mtgt [64];
    int          mc   [64];
    bit          mvd;
    logic [31:0] mpcd;
    bit          mptd;
    logic [31:0] mptgtd;

    branch_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (pcf),
        .StallD      (stall_d),
        .FlushD      (flush_d),
        .Branch_D    (branch_d),
        .PCSrcD      (pcsrc_d),
        .PCBranchD   (pcbranch_d),
        .PredTakenF  (pred_taken_f),
        .PredTargetF (pred_target_f),
        .MispredictD (mispredict_d),
        .RecoverPCD  (recover_pc_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mv[m_idx(pc)] && (mtag[m_idx(pc)] == (pc >> 8));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (mc[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pred(pc) ? mtgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_isb();
        return mvd && (branch_d >= 3'd1) && (branch_d <= 3'd6);
    endfunction

    always @(posedge clk) begin
        bit          pf;
        logic [31:0] pt;
        int          di;
        pf = m_pred(pcf);
        pt = m_ptgt(pcf);
        di = m_idx(mpcd);
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                mv[i] = 0;
                mc[i] = 1;
            end
            mvd = 0; mpcd = 0; mptd = 0; mptgtd = 0;
        end else begin
            if (!stall_d) begin
                if (m_isb()) begin
                    if (m_hit(mpcd)) begin
                        if (pcsrc_d) begin
                            mc[di] = (mc[di] < 3) ? mc[di] + 1 : 3;
                            mtgt[di] = pcbranch_d;
                        end else begin
                            mc[di] = (mc[di] > 0) ? mc[di] - 1 : 0;
                        end
                    end else if (pcsrc_d) begin
                        mv[di] = 1;
                        mtag[di] = mpcd >> 8;
                        mtgt[di] = pcbranch_d;
                        mc[di] = 2;
                    end
                end else if (mvd && mptd) begin
                    mv[di] = 0;
                end
            end
            if (flush_d) begin
                mvd = 0; mptd = 0;
            end else if (!stall_d) begin
                mvd = 1; mpcd = pcf; mptd = pf; mptgtd = pt;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit          isb;
        bit          emis;
        logic [31:0] erec;
        if (chk_en) begin
            isb  = m_isb();
            emis = (isb && ((pcsrc_d != mptd)
                            || (pcsrc_d && (mptgtd != pcbranch_d))))
                   || (mvd && !isb && mptd);
            erec = (isb && pcsrc_d) ? pcbranch_d : mpcd + 32'd4;
            chk("m_pred_taken", 32'(pred_taken_f), 32'(m_pred(pcf)));
            chk("m_pred_target", pred_target_f, m_ptgt(pcf));
            chk("m_mispredict", 32'(mispredict_d), 32'(emis));
            chk("m_recover_pc", recover_pc_d, erec);
        end
    end

    task automatic cyc(input logic [31:0] pc, input logic [2:0] br,
                       input logic src, input logic [31:0] tgt,
                       input logic st, input logic fl);
        @(posedge clk);
        #1;
        pcf = pc; branch_d = br; pcsrc_d = src;
        pcbranch_d = tgt; stall_d = st; flush_d = fl;
        @(negedge clk);
    endtask

    initial begin
        rst = 1; pcf = 0; branch_d = 0; pcsrc_d = 0;
        pcbranch_d = 0; stall_d = 0; flush_d = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;
        pcf = 32'h0040_0010;
        @(negedge clk);
        chk("rst_pred", 32'(pred_taken_f), 32'd0);
        chk("rst_target", pred_target_f, 32'h0040_0014);
        chk("rst_mis", 32'(mispredict_d), 32'd0);
        chk("rst_recover", recover_pc_d, 32'h4);

        cyc(32'h100, 0, 0, 0, 0, 0);
        cyc(32'h308, 3, 1, 32'h200, 0, 0);
        chk("cold_mis", 32'(mispredict_d), 32'd1);
        chk("cold_recover", recover_pc_d, 32'h200);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("learn_pred", 32'(pred_taken_f), 32'd1);
        chk("learn_target", pred_target_f, 32'h200);

        for (int k = 0; k < 3; k++) begin
            cyc(32'h308, 3, 1, 32'h200, 0, 0);
            chk("sat_taken_mis", 32'(mispredict_d), 32'd0);
            cyc(32'h100, 0, 0, 0, 0, 0);
        end
        cyc(32'h308, 3, 0, 0, 0, 0);
        chk("nt1_mis", 32'(mispredict_d), 32'd1);
        chk("nt1_recover", recover_pc_d, 32'h104);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("nt1_pred", 32'(pred_taken_f), 32'd1);
        cyc(32'h308, 3, 0, 0, 0, 0);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("nt2_pred", 32'(pred_taken_f), 32'd0);

        cyc(32'h308, 3, 1, 32'h200, 0, 0);
        cyc(32'h4100, 0, 0, 0, 0, 0);
        chk("alias_miss", 32'(pred_taken_f), 32'd0);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("alias_pre", 32'(pred_taken_f), 32'd1);
        cyc(32'h308, 0, 0, 0, 0, 0);
        chk("alias_mis", 32'(mispredict_d), 32'd1);
        chk("alias_recover", recover_pc_d, 32'h104);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("alias_inval", 32'(pred_taken_f), 32'd0);

        cyc(32'h308, 3, 1, 32'h200, 0, 0);
        cyc(32'h100, 0, 0, 0, 0, 0);
        cyc(32'h308, 3, 0, 0, 0, 0);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("stall_pre", 32'(pred_taken_f), 32'd0);
        cyc(32'h308, 3, 1, 32'h200, 1, 0);
        chk("stall_mis1", 32'(mispredict_d), 32'd1);
        cyc(32'h308, 3, 1, 32'h200, 1, 0);
        chk("stall_mis2", 32'(mispredict_d), 32'd1);
        cyc(32'h308, 3, 1, 32'h200, 0, 0);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("stall_once_a", 32'(pred_taken_f), 32'd1);
        cyc(32'h308, 3, 0, 0, 0, 0);
        cyc(32'h100, 0, 0, 0, 0, 0);
        chk("stall_once_b", 32'(pred_taken_f), 32'd0);

        cyc(32'h100, 0, 0, 0, 0, 1);
        cyc(32'h308, 3, 1, 32'h999, 0, 0);
        chk("flush_mis", 32'(mispredict_d), 32'd0);

        cyc(32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        chk("wrap_pred", 32'(pred_taken_f), 32'd0);
        chk("wrap_target", pred_target_f, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            logic [31:0] tgt;
            if ($urandom_range(0, 7) == 0)
                pc = $urandom & 32'hFFFF_FFFC;
            else
                pc = (32'($urandom_range(0, 3)) << 8)
                     | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 1) == 0)
                tgt = 32'($urandom_range(0, 3)) << 4;
            else
                tgt = $urandom & 32'hFFFF_FFFC;
            cyc(pc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                tgt, $urandom_range(0, 6) == 0,
                $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1;
                cyc(pc, 3'd2, 1'b1, tgt, 1'b0, 1'b0);
                rst = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It sits on the consumer side of the decode-stage branch decision. In fetch it predicts direction and target for PCF. In decode it takes the resolved outcome (PCSrcD, PCBranchD, Branch_D), flags mispredictions with a recovery PC, and trains its tables.

## Interface
- IDX_BITS, 6, log2 of table entries (64 entries)
- ADDR_W, 32, address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- PCF  in  ADDR_W  fetch-stage PC (word aligned)
- StallD  in  1  hold the F→D prediction register
- FlushD  in  1  invalidate the F→D prediction register
- Branch_D  in  3  decode branch type; 3'b001–3'b110 = branch, 3'b000/3'b111 = non-branch
- PCSrcD  in  1  resolved taken flag from the branch unit
- PCBranchD  in  ADDR_W  resolved branch target
- PredTakenF  out  1  predict taken for PCF
- PredTargetF  out  ADDR_W  next-PC prediction for PCF
- MispredictD  out  1  decode-stage misprediction; fetch must redirect
- RecoverPCD  out  ADDR_W  correct next PC when MispredictD=1

## Operation
- Index = PCF[IDX_BITS+1:2]. Tag = PCF[ADDR_W-1:IDX_BITS+2].
- Per entry: valid bit, tag, target (ADDR_W), 2-bit counter.
- Fetch path is combinational:
  - hit = valid & tag match.
  - PredTakenF = hit & ctr[1].
  - PredTargetF = target when PredTakenF, else PCF+4.
- F→D register holds ValidD, PCD, PredTakenD and PredTargetD. Priority order:
  - rst: clear all fields.
  - else FlushD: ValidD=0, PredTakenD=0.
  - else StallD: hold.
  - else load ValidD=1, PCD=PCF, PredTakenD=PredTakenF, PredTargetD=PredTargetF.
- IsBranch = ValidD & (Branch_D ∈ {1..6}).
- Misprediction conditions (combinational):
  - Branch: MispredictD = IsBranch & (PCSrcD≠PredTakenD | (PCSrcD & PredTargetD≠PCBranchD)).
  - Alias: ValidD & !IsBranch & PredTakenD also asserts MispredictD.
  - RecoverPCD = (IsBranch & PCSrcD) ? PCBranchD : PCD+4.
- Training happens on the clock edge when IsBranch & !StallD, at entry[PCD index]:
  - Hit: counter +1 saturating at 2'b11 if PCSrcD, else -1 saturating at 2'b00. If PCSrcD, also write target=PCBranchD.
  - Miss, PCSrcD=1: allocate valid=1, tag, target=PCBranchD, counter=2'b10. Replacement is unconditional.
  - Miss, PCSrcD=0: no change.
- Alias case (ValidD & !IsBranch & PredTakenD & !StallD): clear valid of entry[PCD index].
- Arithmetic: PC+4 wraps modulo 2^ADDR_W. Counters never wrap.

## Timing
- Reset, effective at the first rising edge with rst=1:
  - All valid=0, all counters=2'b01, ValidD=0, PCD=0, PredTakenD=0, PredTargetD=0.
- Outputs after reset: PredTakenF=0, PredTargetF=PCF+4, MispredictD=0, RecoverPCD=4.
- rst asserted mid-operation discards any pending update in that cycle.
- Prediction latency: 0 cycles (same cycle as PCF).
- Training latency: the update is visible to a PCF lookup in the cycle after the resolving edge.
- Same-cycle lookup and update of the same index: the lookup sees pre-update contents (no bypass).
- MispredictD is valid in the same cycle as PCSrcD. It is not registered.
- While StallD=1, MispredictD may be asserted but tables are not written. The update happens once, in the non-stalled cycle.
- FlushD suppresses both MispredictD and training on the next cycle, because ValidD=0.

## Test plan
- Reset, then PCF=0x0040_0010 → PredTakenF=0, PredTargetF=0x0040_0014, MispredictD=0.
- Cold taken branch: PCF=0x100, next cycle Branch_D=3'b011, PCSrcD=1, PCBranchD=0x200.
  - Same cycle: MispredictD=1, RecoverPCD=0x200.
  - Next PCF=0x100: PredTakenF=1, PredTargetF=0x200.
- Counter saturation at PC 0x100:
  - Taken three more times: counter reaches 2'b11 and stays.
  - Then not-taken once: counter 2'b10, still predicts taken. Mispredict on that branch with RecoverPCD=0x104.
  - Second not-taken: counter 2'b01 → PredTakenF=0.
- Alias: PC 0x4100 shares an index with 0x100 (IDX_BITS=6) and carries a different tag → miss, PredTakenF=0.
  - Non-branch decoded while PredTakenD=1: MispredictD=1, RecoverPCD=PCD+4, entry invalidated.
- Stall/flush:
  - StallD=1 for 2 cycles during a taken branch: training occurs exactly once, on the non-stalled cycle.
  - FlushD=1: next cycle MispredictD=0 regardless of Branch_D/PCSrcD.
- Wrap: PCF=0xFFFF_FFFC on a miss → PredTargetF=0x0000_0000.
